acquisition_accumulator: RTL and testbench
==========================================

Name: acquisition_accumulator

Overview:
Parametrised multi-pass waveform accumulator, successor to the single-mode BCM acquisition engine. It captures CHANNEL_COUNT x SAMPLES_PER_CLOCK lanes per clock into an internal RAM and, over N contiguous passes, combines each pass into the RAM element by element. It adds a programmable post-trigger delay, selectable SUM/MAX/MIN combining, abort, and an in-domain readout port. It sits in the ADC clock domain; the caller provides any clock crossing.

Parameters:
CHANNEL_COUNT, 2, number of ADC channels
SAMPLES_PER_CLOCK, 4, samples per channel per clock
SAMPLE_WIDTH, 16, width of each input lane field (ADC value left-justified)
ADC_WIDTH, 14, significant ADC bits per lane
WORD_CAPACITY, 256, RAM depth in clock words (power of two)
MAX_PASSES, 256, maximum passes per acquisition (power of two)
DELAY_WIDTH, 16, width of the post-trigger delay counter

Ports:
clk  in  1  ADC clock; the only clock
rst  in  1  asynchronous, active-high reset
arm  in  1  pulse; latches cfg* and arms (IDLE only)
abort  in  1  pulse; cancels any acquisition
trigger  in  1  single-cycle trigger qualifier
tagIn  in  1  qualifier latched at trigger, e.g. injection flag
cfgWordCount  in  log2(WORD_CAPACITY)  words per pass minus 1
cfgPassCount  in  log2(MAX_PASSES)+1  passes; 0 is treated as 1
cfgDelay  in  DELAY_WIDTH  cycles from trigger to first capture
cfgMode  in  2  0=SUM, 1=MAX, 2=MIN, 3=SUM
adcData  in  CHANNEL_COUNT*SAMPLES_PER_CLOCK*SAMPLE_WIDTH  lane data, lane i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
rdAddr  in  log2(WORD_CAPACITY)  readout word address
rdLane  in  log2(CHANNEL_COUNT*SAMPLES_PER_CLOCK)  readout lane
rdData  out  32  selected accumulator, sign-extended, shifted left by SAMPLE_WIDTH-ADC_WIDTH
armed  out  1  ARMED state
busy  out  1  DELAY, CAPTURE or DRAIN state
done  out  1  set at acquisition completion; cleared by arm or abort
tagOut  out  1  tagIn value latched at the accepted trigger
passIndex  out  log2(MAX_PASSES)+1  passes completed in the current acquisition

Behaviour:
- Reset: state IDLE; armed, busy, done, tagOut all 0; passIndex 0; rdData 0. RAM contents are undefined.
- States: IDLE -> ARMED on arm. ARMED -> DELAY on trigger; tagOut <= tagIn. DELAY -> CAPTURE after exactly cfgDelay cycles; cfgDelay=0 gives the first capture in the cycle after trigger. CAPTURE -> DRAIN after the last word of the last pass. DRAIN -> IDLE after 3 cycles; done <= 1 on that transition.
- Config is latched on arm. Effective word count W = max(cfgWordCount+1, 4). This minimum guarantees a read-modify-write never overlaps the same address.
- Passes are contiguous: word address counts 0..W-1 and wraps to 0 with no gap cycle. passIndex increments on each wrap.
- Pipeline: address issued at t; RAM Q at t+1; combine at t+2; write at t+3. Input sample for address a must be presented at cycle t.
- Pass 0 writes the sign-extended sample, ignoring RAM contents. Later passes combine as SUM (old+new), MAX (signed larger) or MIN (signed smaller).
- Accumulator width is ADC_WIDTH + log2(MAX_PASSES), which cannot overflow.
- abort: from any state, return to IDLE next cycle; done stays 0; in-flight writes are suppressed.
- arm outside IDLE is ignored. trigger outside ARMED is ignored. arm and trigger in the same IDLE cycle: arm only.
- Readout: rdData is valid 2 cycles after rdAddr/rdLane are stable. It is valid only in IDLE; during busy the RAM port belongs to the acquisition and rdData holds its last value.

Decomposition:
- Package acq_accum_pkg: mode encodings (MODE_SUM, MODE_MAX, MODE_MIN), state enum, PIPE_DEPTH=3, MIN_WORDS=4, and width functions (accumulator width, address width).
- Sub-module acq_accum_lane: one per lane. It holds the sign-extend, combine mux and pipeline registers for a single accumulator.

Test Plan:
- SUM, W=8, passes=4, delay=0, every lane a constant +100 -> all 8 words read 400 (shifted by SAMPLE_WIDTH-ADC_WIDTH); done=1; passIndex=4.
- MAX, W=4, passes=3, lane 0 ramp per pass {5,-3,9} -> each word reads 9. MIN with the same stimulus -> each word reads -3.
- cfgDelay=10, marker sample at trigger+11 -> marker lands at word 0; cfgWordCount=1 -> W is clamped to 4 (passIndex steps every 4 cycles).
- Full-scale -8192 for MAX_PASSES=256 passes -> -2097152 with no wrap; the sign is correct on rdData.
- Abort mid-pass 2 -> IDLE next cycle, done=0, busy=0; a subsequent arm+trigger completes normally.
- Trigger before arm, and a second trigger during DELAY -> both ignored; tagOut equals tagIn at the accepted trigger only.

Source files
------------

// File: rtl/acq_accum_pkg.sv
// acq_accum_pkg: shared modes, states, pipeline constants and width helpers for the accumulator
package acq_accum_pkg;
  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam int PIPE_DEPTH = 3;
  localparam int MIN_WORDS = 4;
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DRAIN} acqStateT;
  function automatic int accWidth(input int adcWidth, input int maxPasses);
    return adcWidth + $clog2(maxPasses);
  endfunction
  function automatic int addrWidth(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/acq_accum_lane.sv
// acq_accum_lane: one accumulator lane (RAM, sign-extend, combine, 3-stage read-modify-write)
// Ports: clk/rst, abort suppresses in-flight writes, capture/firstPass/mode qualify the
// sample at addr, q is the registered RAM output shared by capture and readout.
module acq_accum_lane
  import acq_accum_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADC_WIDTH = 14,
  parameter int ACC_WIDTH = 22,
  parameter int WORD_CAPACITY = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  input  logic capture,
  input  logic firstPass,
  input  logic [1:0] mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0] q
);
  logic signed [ACC_WIDTH-1:0] mem [WORD_CAPACITY];
  logic signed [SAMPLE_WIDTH-1:0] s1;
  logic signed [ACC_WIDTH-1:0] x1, combined, acc2;
  logic [ADDR_WIDTH-1:0] a1, a2;
  logic v1, v2, f1;
  // ADC value is left-justified: arithmetic shift drops the pad bits and keeps the sign
  assign x1 = ACC_WIDTH'(s1 >>> (SAMPLE_WIDTH - ADC_WIDTH));
  always_comb begin
    combined = f1 ? x1 :
               mode == MODE_MAX ? (q > x1 ? q : x1) :
               mode == MODE_MIN ? (q < x1 ? q : x1) : q + x1;
  end
  always_ff @(posedge clk) begin
    q <= mem[addr];
    if (v2 && !abort) mem[a2] <= acc2;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      f1 <= 1'b0;
      s1 <= '0;
      a1 <= '0;
      a2 <= '0;
      acc2 <= '0;
    end else begin
      v1 <= capture && !abort;
      v2 <= v1 && !abort;
      f1 <= firstPass;
      s1 <= sample;
      a1 <= addr;
      a2 <= a1;
      acc2 <= combined;
    end
  end
endmodule

// File: rtl/acquisition_accumulator.sv
// acquisition_accumulator: multi-pass SUM/MAX/MIN waveform accumulator with delay, abort and readout
// Ports: arm/abort/trigger/tagIn control, cfg* latched on arm, adcData lanes in;
// rdAddr/rdLane -> rdData readout; armed/busy/done/tagOut/passIndex status.
module acquisition_accumulator
  import acq_accum_pkg::*;
#(
  parameter int CHANNEL_COUNT = 2,
  parameter int SAMPLES_PER_CLOCK = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADC_WIDTH = 14,
  parameter int WORD_CAPACITY = 256,
  parameter int MAX_PASSES = 256,
  parameter int DELAY_WIDTH = 16,
  localparam int LANES = CHANNEL_COUNT * SAMPLES_PER_CLOCK,
  localparam int AW = addrWidth(WORD_CAPACITY),
  localparam int PW = $clog2(MAX_PASSES) + 1,
  localparam int LW = $clog2(LANES)
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic abort,
  input  logic trigger,
  input  logic tagIn,
  input  logic [AW-1:0] cfgWordCount,
  input  logic [PW-1:0] cfgPassCount,
  input  logic [DELAY_WIDTH-1:0] cfgDelay,
  input  logic [1:0] cfgMode,
  input  logic [LANES*SAMPLE_WIDTH-1:0] adcData,
  input  logic [AW-1:0] rdAddr,
  input  logic [LW-1:0] rdLane,
  output logic [31:0] rdData,
  output logic armed,
  output logic busy,
  output logic done,
  output logic tagOut,
  output logic [PW-1:0] passIndex
);
  localparam int ACC = accWidth(ADC_WIDTH, MAX_PASSES);
  acqStateT state, nextState;
  logic [AW-1:0] wordAddr, lastWord, ramAddr;
  logic [PW-1:0] passTotal;
  logic [DELAY_WIDTH-1:0] delayCfg, delayCnt;
  logic [1:0] mode, drainCnt;
  logic [LW-1:0] rdLaneD;
  logic signed [ACC-1:0] laneQ [LANES];
  logic wrap, lastPass;
  assign wrap = wordAddr == lastWord;
  assign lastPass = passIndex + PW'(1) == passTotal;
  assign ramAddr = state == CAPTURE ? wordAddr : rdAddr;
  assign armed = state == ARMED;
  assign busy = state == DELAY || state == CAPTURE || state == DRAIN;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (arm) nextState = ARMED;
      ARMED:   if (trigger) nextState = delayCfg == '0 ? CAPTURE : DELAY;
      DELAY:   if (delayCnt == DELAY_WIDTH'(1)) nextState = CAPTURE;
      CAPTURE: if (wrap && lastPass) nextState = DRAIN;
      DRAIN:   if (drainCnt == 2'(PIPE_DEPTH - 1)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastWord <= AW'(MIN_WORDS - 1);
      passTotal <= PW'(1);
      delayCfg <= '0;
      mode <= MODE_SUM;
      delayCnt <= '0;
      drainCnt <= '0;
      wordAddr <= '0;
      passIndex <= '0;
      done <= 1'b0;
      tagOut <= 1'b0;
      rdLaneD <= '0;
      rdData <= '0;
    end else begin
      if (state == IDLE && arm) begin
        // a minimum pass length keeps each read clear of its own pending write
        lastWord <= cfgWordCount < AW'(MIN_WORDS - 1) ? AW'(MIN_WORDS - 1) : cfgWordCount;
        passTotal <= cfgPassCount == '0 ? PW'(1) : cfgPassCount;
        delayCfg <= cfgDelay;
        mode <= cfgMode;
        passIndex <= '0;
      end
      if (state == ARMED && trigger && !abort) tagOut <= tagIn;
      delayCnt <= state == ARMED ? delayCfg : delayCnt - DELAY_WIDTH'(state == DELAY);
      drainCnt <= state == DRAIN ? drainCnt + 2'd1 : 2'd0;
      wordAddr <= state == CAPTURE && !wrap ? wordAddr + AW'(1) : '0;
      if (state == CAPTURE && wrap) passIndex <= passIndex + PW'(1);
      done <= (state == IDLE && arm) || abort ? 1'b0 :
              state == DRAIN && nextState == IDLE ? 1'b1 : done;
      rdLaneD <= rdLane;
      if (!busy) rdData <= 32'(laneQ[rdLaneD]) << (SAMPLE_WIDTH - ADC_WIDTH);
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    acq_accum_lane #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .ADC_WIDTH(ADC_WIDTH),
      .ACC_WIDTH(ACC),
      .WORD_CAPACITY(WORD_CAPACITY),
      .ADDR_WIDTH(AW)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .abort(abort),
      .capture(state == CAPTURE),
      .firstPass(passIndex == '0),
      .mode(mode),
      .addr(ramAddr),
      .sample(adcData[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .q(laneQ[i])
    );
  end
endmodule

// File: tb/tb_acquisition_accumulator.sv
// tb_acquisition_accumulator: randomized scoreboard bench for acquisition_accumulator
module tb_acquisition_accumulator;
  localparam int LANES = 8;
  logic clk = 1'b0;
  logic rst, arm, abort, trigger, tagIn;
  logic [7:0] cfgWordCount;
  logic [8:0] cfgPassCount;
  logic [15:0] cfgDelay;
  logic [1:0] cfgMode;
  logic [LANES*16-1:0] adcData;
  logic [7:0] rdAddr;
  logic [2:0] rdLane;
  logic [31:0] rdData;
  logic armed, busy, done, tagOut;
  logic [8:0] passIndex;
  int checks = 0, errors = 0;
  int model [256][LANES];
  int expQ [$];
  logic rdIssue = 1'b0, p1 = 1'b0, p2 = 1'b0;

  acquisition_accumulator dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trigger(trigger), .tagIn(tagIn),
    .cfgWordCount(cfgWordCount), .cfgPassCount(cfgPassCount), .cfgDelay(cfgDelay),
    .cfgMode(cfgMode), .adcData(adcData), .rdAddr(rdAddr), .rdLane(rdLane),
    .rdData(rdData), .armed(armed), .busy(busy), .done(done), .tagOut(tagOut),
    .passIndex(passIndex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // readout valid is two cycles after the address; the monitor follows that delay
  always @(posedge clk) begin
    p1 <= rdIssue;
    p2 <= p1;
  end
  always @(negedge clk) begin
    if (p2) begin
      if (expQ.size() == 0) chk("rd_queue_empty", 1, 0);
      else chk("rdData", $signed(rdData), expQ.pop_front());
    end
  end

  function automatic int gen(input int kind, input int p, input int l);
    if (kind == 1) return 100;
    if (kind == 3) return -8192;
    if (kind == 2 && l == 0) return p == 0 ? 5 : p == 1 ? -3 : 9;
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic readAll(input int w);
    for (int a = 0; a < w; a++)
      for (int l = 0; l < LANES; l++) begin
        rdAddr = 8'(a);
        rdLane = 3'(l);
        rdIssue = 1'b1;
        expQ.push_back(model[a][l] * 4);
        step;
      end
    rdIssue = 1'b0;
    repeat (4) step;
    chk("rd_queue_drained", expQ.size(), 0);
  endtask

  task automatic startAcq(input int wc, input int pc, input int dl, input int md,
                          input bit tag, input bit extra);
    if (extra) begin
      tagIn = 1'b1;
      trigger = 1'b1;
      step;
      trigger = 1'b0;
      chk("pretrig_armed", armed, 0);
      chk("pretrig_busy", busy, 0);
    end
    cfgWordCount = 8'(wc);
    cfgPassCount = 9'(pc);
    cfgDelay = 16'(dl);
    cfgMode = 2'(md);
    arm = 1'b1;
    trigger = extra;
    step;
    arm = 1'b0;
    trigger = 1'b0;
    chk("armed", armed, 1);
    chk("arm_busy", busy, 0);
    chk("arm_done_clr", done, 0);
    tagIn = tag;
    trigger = 1'b1;
    step;
    trigger = 1'b0;
    tagIn = ~tag;
    chk("trig_armed", armed, 0);
    if (dl > 0) chk("delay_busy", busy, 1);
    for (int i = 0; i < dl; i++) begin
      trigger = extra && i == 0;
      step;
    end
    trigger = 1'b0;
    chk("tagOut", tagOut, tag);
  endtask

  task automatic runAcq(input int wc, input int pc, input int dl, input int md,
                        input int kind, input bit tag, input bit extra);
    int w, p, v;
    w = wc + 1 < 4 ? 4 : wc + 1;
    p = pc == 0 ? 1 : pc;
    startAcq(wc, pc, dl, md, tag, extra);
    for (int q = 0; q < p; q++)
      for (int a = 0; a < w; a++) begin
        if (a == 0) begin
          chk("passIndex_step", int'(passIndex), q);
          chk("capture_busy", busy, 1);
        end
        for (int l = 0; l < LANES; l++) begin
          v = gen(kind, q, l);
          adcData[l*16 +: 16] = 16'(v * 4 + int'($urandom_range(0, 3)));
          model[a][l] = q == 0 ? v : md == 1 ? (v > model[a][l] ? v : model[a][l]) :
                        md == 2 ? (v < model[a][l] ? v : model[a][l]) : model[a][l] + v;
        end
        step;
      end
    adcData = '0;
    repeat (3) step;
    chk("done", done, 1);
    chk("end_busy", busy, 0);
    chk("passIndex_final", int'(passIndex), p);
    readAll(w);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; tagIn = 1'b0;
    cfgWordCount = '0; cfgPassCount = '0; cfgDelay = '0; cfgMode = '0;
    adcData = '0; rdAddr = '0; rdLane = '0;
    repeat (3) step;
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tagOut", tagOut, 0);
    chk("rst_passIndex", int'(passIndex), 0);
    chk("rst_rdData", $signed(rdData), 0);
    rst = 1'b0;
    step;
    runAcq(7, 4, 0, 0, 1, 1'b1, 1'b0);
    chk("sum_const_word7", model[7][3] * 4, 1600);
    runAcq(3, 3, 0, 1, 2, 1'b0, 1'b0);
    runAcq(3, 3, 0, 2, 2, 1'b1, 1'b0);
    runAcq(1, 2, 10, 0, 0, 1'b0, 1'b0);
    runAcq(0, 256, 0, 0, 3, 1'b1, 1'b0);
    startAcq(7, 4, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      adcData = {$urandom, $urandom, $urandom, $urandom};
      step;
    end
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_armed", armed, 0);
    chk("abort_done", done, 0);
    repeat (4) step;
    chk("abort_stays_idle", busy, 0);
    runAcq(7, 4, 2, 1, 0, 1'b1, 1'b0);
    runAcq(5, 3, 4, 2, 0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      runAcq($urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 5),
             $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)), 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
